// File: rtl/rs_pkg.sv
// GF(2^8) arithmetic and Reed-Solomon generator-polynomial helpers shared by the RS encoder and decoder.
// Everything here is evaluated at elaboration; the decoder reuses the same roots for its syndromes.
package rs_pkg;

   localparam int         GF_W         = 8;
   localparam logic [8:0] POLY_DEFAULT = 9'h11D;
   localparam int         NSYM_MAX     = 32;

   typedef logic [GF_W-1:0]                 gf_t;
   typedef logic [NSYM_MAX-1:0][GF_W-1:0]   gf_vec_t;
   typedef enum logic {MSG = 1'b0, PARITY = 1'b1} rs_state_t;

   function automatic gf_t gf_mul(input gf_t a, input gf_t b, input logic [8:0] poly);
      gf_t        acc;
      gf_t        sh;
      logic [8:0] t;
      acc = '0;
      sh  = a;
      for (int i = 0; i < GF_W; i++) begin
         if (b[i]) acc = acc ^ sh;
         t = {sh, 1'b0};
         if (t[8]) t = t ^ poly;
         sh = t[7:0];
      end
      return acc;
   endfunction

   // g(x) = prod (x + alpha^i), i = 0..nsym-1, alpha = 0x02; returns g[0..nsym-1], monic term implicit.
   function automatic gf_vec_t rs_gen_poly(input int nsym, input logic [8:0] poly);
      gf_t     g [0:NSYM_MAX];
      gf_t     root;
      gf_vec_t res;
      for (int j = 0; j <= NSYM_MAX; j++) g[j] = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < NSYM_MAX; i++) begin
         if (i < nsym) begin
            for (int j = NSYM_MAX; j >= 1; j--)
               g[j] = g[j-1] ^ gf_mul(g[j], root, poly);
            g[0] = gf_mul(g[0], root, poly);
            root = gf_mul(root, 8'h02, poly);
         end
      end
      res = '0;
      for (int j = 0; j < NSYM_MAX; j++)
         if (j < nsym) res[j] = g[j];
      return res;
   endfunction

endpackage

// File: rtl/rs_gf_const_mul.sv
// Multiplies a GF(2^8) symbol by an elaboration-time constant.
// Combinational XOR network: each input bit contributes one precomputed column.
module rs_gf_const_mul
   import rs_pkg::*;
#(
   parameter gf_t        C    = 8'h01,
   parameter logic [8:0] POLY = POLY_DEFAULT
) (
   input  logic [GF_W-1:0] a,
   output logic [GF_W-1:0] y
);

   function automatic logic [GF_W-1:0][GF_W-1:0] columns(input gf_t c, input logic [8:0] poly);
      logic [GF_W-1:0][GF_W-1:0] col;
      for (int j = 0; j < GF_W; j++)
         col[j] = gf_mul(gf_t'(1 << j), c, poly);
      return col;
   endfunction

   localparam logic [GF_W-1:0][GF_W-1:0] COL = columns(C, POLY);

   always_comb begin
      y = '0;
      for (int j = 0; j < GF_W; j++)
         y = y ^ (COL[j] & {GF_W{a[j]}});
   end

endmodule

// File: rtl/rs_encoder_stream.sv
// Systematic RS(K+NSYM, K) encoder over GF(2^8): message symbols pass through, then NSYM parity symbols.
// One output register (1-cycle latency); m_ready low freezes the LFSR, counters and state.
module rs_encoder_stream
   import rs_pkg::*;
#(
   parameter int         NSYM = 4,
   parameter int         K    = 251,
   parameter logic [8:0] POLY = POLY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       m_last
);

   localparam int            PW       = (NSYM > 2) ? $clog2(NSYM) : 1;
   localparam gf_vec_t       G        = rs_gen_poly(NSYM, POLY);
   localparam logic [7:0]    MSG_LAST = 8'(K - 1);
   localparam logic [PW-1:0] PAR_LAST = PW'(NSYM - 1);

   rs_state_t            state;
   rs_state_t            state_nxt;
   logic                 run;
   logic [7:0]           msg_cnt;
   logic [PW-1:0]        par_cnt;
   logic [NSYM-1:0][7:0] r;
   logic [NSYM-1:0][7:0] r_nxt;
   logic [NSYM-1:0][7:0] gm;
   logic [7:0]           fb;
   logic                 out_free;
   logic                 in_xfer;
   logic                 par_load;

   assign fb = s_data ^ r[NSYM-1];

   for (genvar i = 0; i < NSYM; i++) begin : g_tap
      rs_gf_const_mul #(.C(G[i]), .POLY(POLY)) u_mul (
         .a (fb),
         .y (gm[i])
      );
   end

   always_comb begin
      r_nxt    = '0;
      r_nxt[0] = gm[0];
      for (int i = 1; i < NSYM; i++)
         r_nxt[i] = r[i-1] ^ gm[i];
   end

   // Keeps s_ready low while rst is asserted without a combinational path from rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) run <= 1'b0;
      else     run <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MSG;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      in_xfer   = 1'b0;
      par_load  = 1'b0;
      out_free  = !m_valid || m_ready;
      case (state)
         MSG: begin
            s_ready = run && out_free;
            in_xfer = s_valid && s_ready;
            if (in_xfer && msg_cnt == MSG_LAST) state_nxt = PARITY;
         end
         PARITY: begin
            par_load = out_free;
            if (par_load && par_cnt == PAR_LAST) state_nxt = MSG;
         end
         default: state_nxt = MSG;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r       <= '0;
         msg_cnt <= '0;
         par_cnt <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else if (in_xfer) begin
         r       <= r_nxt;
         m_data  <= s_data;
         m_valid <= 1'b1;
         m_last  <= 1'b0;
         msg_cnt <= (msg_cnt == MSG_LAST) ? 8'd0 : msg_cnt + 8'd1;
      end else if (par_load) begin
         // Shifting a zero in means r is all-zero once the last parity symbol leaves.
         r       <= {r[NSYM-2:0], 8'h00};
         m_data  <= r[NSYM-1];
         m_valid <= 1'b1;
         m_last  <= (par_cnt == PAR_LAST);
         par_cnt <= (par_cnt == PAR_LAST) ? '0 : par_cnt + PW'(1);
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Directed bench for rs_encoder_stream (NSYM=4, K=251): impulses, zero, random stalls, back-to-back, reset abort.
module tb_rs_encoder_stream;
   import rs_pkg::*;

   localparam int NSYM = 4;
   localparam int K    = 251;
   localparam int N    = K + NSYM;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data  = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_last;

   int total = 0;
   int bad   = 0;

   logic [7:0] msg_q [$];
   logic [8:0] out_q [$];
   logic [7:0] exp_par [4];
   int         first_fire;
   int         last_fire;
   int         low_cnt;

   rs_encoder_stream #(.NSYM(NSYM), .K(K), .POLY(9'h11D)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Carry-less product followed by reduction modulo 0x11D.
   function automatic logic [7:0] tgmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011D << (i - 8));
      return p[7:0];
   endfunction

   // Long division of m(x)*x^4 by g(x) = x^4+0F x^3+36 x^2+78 x+40.
   task automatic model_parity(input int mbase);
      logic [7:0] d  [N];
      logic [7:0] gd [5];
      logic [7:0] c;
      gd = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
      for (int i = 0; i < N; i++) d[i] = (i < K) ? msg_q[mbase + i] : 8'h00;
      for (int i = 0; i < K; i++) begin
         c = d[i];
         for (int j = 1; j <= NSYM; j++) d[i + j] = d[i + j] ^ tgmul(c, gd[j]);
      end
      for (int j = 0; j < NSYM; j++) exp_par[j] = d[K + j];
   endtask

   task automatic drive(input int idx, input bit stall);
      s_valid = (idx < msg_q.size()) && (!stall || $urandom_range(0, 1) == 1);
      s_data  = (idx < msg_q.size()) ? msg_q[idx] : 8'h00;
      m_ready = !stall || ($urandom_range(0, 1) == 1);
   endtask

   task automatic run(input string tag, input int n_out, input bit stall);
      int         idx;
      int         cyc;
      bit         in_fire;
      bit         out_fire;
      bit         held;
      logic [8:0] hv;
      idx = 0; cyc = 0; held = 1'b0; hv = '0;
      out_q.delete();
      first_fire = -1; last_fire = -1; low_cnt = 0;
      drive(idx, stall);
      while (out_q.size() < n_out && cyc < 20000) begin
         @(negedge clk);
         in_fire  = s_valid && s_ready;
         out_fire = m_valid && m_ready;
         if (held) check({tag, ".hold"}, {m_valid, m_last, m_data}, {1'b1, hv});
         held = m_valid && !m_ready;
         hv   = {m_last, m_data};
         if (out_fire) begin
            out_q.push_back({m_last, m_data});
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
         end
         if (!s_ready && idx > 0 && idx < msg_q.size()) low_cnt++;
         cyc++;
         if (out_q.size() < n_out) begin
            @(posedge clk); #1;
            if (in_fire) idx++;
            drive(idx, stall);
         end
      end
      check({tag, ".count"}, out_q.size(), n_out);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic check_cw(input string tag, input int obase, input int mbase);
      int         errs;
      logic [7:0] s;
      logic [7:0] a;
      errs = 0;
      for (int i = 0; i < K; i++)
         if (out_q[obase + i] !== {1'b0, msg_q[mbase + i]}) errs++;
      check({tag, ".pass"}, errs, 0);
      for (int j = 0; j < NSYM; j++)
         check($sformatf("%s.par%0d", tag, j), out_q[obase + K + j], {(j == NSYM - 1), exp_par[j]});
      a = 8'h01;
      for (int j = 0; j < NSYM; j++) begin
         s = 8'h00;
         for (int i = 0; i < N; i++) s = tgmul(s, a) ^ out_q[obase + i][7:0];
         check($sformatf("%s.syn%0d", tag, j), s, 0);
         a = tgmul(a, 8'h02);
      end
   endtask

   task automatic load_impulse(input logic [7:0] v);
      msg_q.delete();
      for (int i = 0; i < K; i++) msg_q.push_back((i == K - 1) ? v : 8'h00);
   endtask

   initial begin
      gf_vec_t gv;

      #1 rst = 1'b1;
      #1;
      check("rst.s_ready", s_ready, 0);
      check("rst.m_valid", m_valid, 0);
      check("rst.m_data",  m_data,  0);
      check("rst.m_last",  m_last,  0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst.s_ready_after", s_ready, 1);

      gv = rs_gen_poly(NSYM, 9'h11D);
      check("gen.g3", gv[3], 8'h0F);
      check("gen.g2", gv[2], 8'h36);
      check("gen.g1", gv[1], 8'h78);
      check("gen.g0", gv[0], 8'h40);

      load_impulse(8'h01);
      run("imp1", N, 1'b0);
      exp_par = '{8'h0F, 8'h36, 8'h78, 8'h40};
      check_cw("imp1", 0, 0);

      load_impulse(8'h02);
      run("imp2", N, 1'b0);
      exp_par = '{8'h1E, 8'h6C, 8'hF0, 8'h80};
      check_cw("imp2", 0, 0);

      load_impulse(8'h00);
      run("zero", N, 1'b0);
      exp_par = '{8'h00, 8'h00, 8'h00, 8'h00};
      check_cw("zero", 0, 0);

      msg_q.delete();
      for (int i = 0; i < 2 * K; i++) msg_q.push_back(8'($urandom));
      run("rnd", 2 * N, 1'b1);
      model_parity(0);
      check_cw("rnd0", 0, 0);
      model_parity(K);
      check_cw("rnd1", N, K);

      msg_q.delete();
      for (int i = 0; i < 3 * K; i++) msg_q.push_back(8'($urandom));
      run("b2b", 3 * N, 1'b0);
      check("b2b.span", last_fire - first_fire + 1, 3 * N);
      check("b2b.s_ready_low", low_cnt, 2 * NSYM);
      for (int c = 0; c < 3; c++) begin
         model_parity(c * K);
         check_cw($sformatf("b2b%0d", c), c * N, c * K);
      end

      msg_q.delete();
      for (int i = 0; i < 100; i++) msg_q.push_back({1'b1, 7'(i)});
      run("abort", 99, 1'b0);
      m_ready = 1'b0;
      check("abort.m_valid_pre", m_valid, 1);
      #1 rst = 1'b1;
      #1;
      check("abort.m_valid", m_valid, 0);
      check("abort.m_data",  m_data,  0);
      check("abort.m_last",  m_last,  0);
      check("abort.s_ready", s_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      load_impulse(8'h01);
      run("post", N, 1'b0);
      exp_par = '{8'h0F, 8'h36, 8'h78, 8'h40};
      check_cw("post", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rs_encoder_stream.md
Name: rs_encoder_stream

Overview:
- Systematic Reed-Solomon encoder over GF(2^8); the transmit-side counterpart of the RS decoder in this codebase.
- Accepts K message symbols on a valid/ready input stream and passes them through unchanged.
- Then emits NSYM parity symbols, completing an N = K+NSYM codeword.
- Parity is the remainder of m(x)·x^NSYM mod g(x), with g(x) = Π(x + α^i), i = 0..NSYM-1, α = 0x02.

Parameters:
- NSYM, 4, number of parity symbols (2..32).
- K, 251, message symbols per codeword (1..255-NSYM).
- POLY, 9'h11D, field primitive polynomial.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- s_valid  input  1  input symbol valid.
- s_ready  output  1  encoder accepts input symbol.
- s_data  input  8  message symbol, first symbol = highest-degree coefficient.
- m_valid  output  1  output symbol valid.
- m_ready  input  1  downstream accepts output symbol.
- m_data  output  8  codeword symbol: K message symbols, then parity, highest-degree parity first.
- m_last  output  1  high with the final parity symbol.

Behaviour:
- Reset values: s_ready=0 during rst (1 in the cycle after release), m_valid=0, m_data=0, m_last=0. LFSR registers, counters and state are cleared to MSG.
- Transfer rules: input transfer when s_valid&s_ready; output transfer when m_valid&m_ready.
- Output register: single register stage. Once m_valid rises, m_data and m_last hold stable until the output transfer.
- State MSG:
  - s_ready = !m_valid | m_ready.
  - On an input transfer: fb = s_data ^ r[NSYM-1]; r[i] = r[i-1] ^ g[i]·fb for i ≥ 1; r[0] = g[0]·fb.
  - On the same edge: m_data <= s_data, m_valid <= 1, msg_cnt++.
  - Latency is 1 cycle, input to output.
  - When the transfer with msg_cnt == K-1 occurs: msg_cnt <= 0, go to PARITY.
- State PARITY:
  - s_ready = 0.
  - Whenever the output register is free or being drained, load m_data <= r[NSYM-1], shift r up by one (r[0] <= 0), par_cnt++.
  - m_last <= (par_cnt == NSYM-1).
  - Parity symbols stream back-to-back when m_ready is held high.
  - After the load with par_cnt == NSYM-1: par_cnt <= 0, r has shifted to all-zero, return to MSG.
  - s_ready is not raised until that last symbol's transfer frees the register. Codewords are therefore never interleaved.
- Throughput: with continuous valid/ready, one symbol per cycle, N cycles per codeword, no bubbles between codewords.
- Backpressure:
  - m_ready=0 holds everything: no LFSR update, no counter change.
  - s_valid may drop at any time between symbols with no effect on the result.
- GF arithmetic:
  - g[i]·fb are constant multiplies, reduced by POLY; addition is XOR.
  - g[] coefficients are computed at elaboration; no runtime programmability.
- Reset mid-codeword: partial codeword discarded; the next accepted symbol starts a new codeword.
- Counter widths: msg_cnt 8 bits, par_cnt $clog2(NSYM) (min 1).

Decomposition:
- Shared package rs_pkg:
  - GF_W=8, POLY default.
  - gf_mul constant function.
  - rs_gen_poly(NSYM) constant function returning g[0..NSYM-1] (monic term implicit).
  - state enum {MSG, PARITY}.
  - Reused by the decoder for syndrome roots.
- One sub-module, rs_gf_const_mul:
  - 8-bit input times elaboration-time constant, purely XOR network.
  - Instantiated NSYM times.

Test Plan:
- Elaboration check, NSYM=4: g = x^4+0x0F x^3+0x36 x^2+0x78 x+0x40 -> bench reads g[3..0] = 0x0F,0x36,0x78,0x40.
- Unit impulse, K=251: 250 zeros then 0x01, m_ready=1 -> 251 pass-through symbols, then parity 0x0F,0x36,0x78,0x40 with m_last on 0x40.
- Linearity: same stimulus with last symbol 0x02 -> parity 0x1E,0x6C,0xF0,0x80. All-zero message -> parity 0x00×4.
- Random messages vs. software model, random s_valid/m_ready stalls (50%):
  - Every codeword matches the model.
  - Resulting codeword syndromes at α^0..α^3 are all 0.
  - m_data stable while m_valid&!m_ready.
- Back-to-back codewords, continuous handshake -> exactly 255 cycles per codeword, s_ready low only during the 4 parity cycles.
- rst asserted after 100 symbols, then the unit-impulse message -> parity 0x0F,0x36,0x78,0x40 (no residue from the aborted codeword); all outputs reset asynchronously without waiting for a clk edge.
